psum_wb_ctrl: RTL and testbench
===============================

Name: psum_wb_ctrl

Overview:
Output-side companion to the input load/execute controller. It drains result vectors from the OFIFO and writes them to the PSUM SRAM, one row per vector. Optionally it performs read-modify-write accumulation against the stored partial sums, then applies ReLU. It is the writer at the far end of the datapath whose input end is the SRAM reader/L0 feeder.

Parameters:
col, 8, number of array columns (lanes per vector)
psum_bw, 16, signed partial-sum width per lane
addr_w, 11, PSUM SRAM address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  one-cycle launch; ignored unless in S_IDLE
num_vec  in  5  vectors to write back; latched at start
base_addr  in  addr_w  first PSUM row; latched at start
acc_en  in  1  1 = read-modify-write accumulate; latched at start
relu_en  in  1  1 = clamp negative lanes to 0 before write; latched at start
ofifo_valid  in  1  OFIFO non-empty; first-word-fall-through
ofifo_out  in  col*psum_bw  OFIFO head vector; lane i at bits [i*psum_bw +: psum_bw]
ofifo_rd  out  1  pop OFIFO head
sram_en  out  1  PSUM SRAM access enable
sram_wr  out  1  1 = write, 0 = read (meaningful only with sram_en)
sram_addr  out  addr_w  PSUM SRAM address
sram_din  out  col*psum_bw  write data
sram_dout  in  col*psum_bw  read data, valid 1 cycle after read access
busy  out  1  high in every state except S_IDLE
done  out  1  one-cycle pulse on run completion

Behaviour:
- Reset values: all outputs 0; state S_IDLE; idx 0; data registers 0.
- S_IDLE:
  - On start, latch num_vec, base_addr, acc_en and relu_en, and clear idx.
  - If num_vec==0, go to S_DONE. Otherwise go to S_POP.
- S_POP:
  - ofifo_rd = ofifo_valid, decoded combinationally from state.
  - When ofifo_valid=1, capture ofifo_out into vec_r. Go to S_RD if acc_en, else S_WR.
  - When ofifo_valid=0, hold state. No SRAM activity.
- S_RD: sram_en=1, sram_wr=0, sram_addr=base+idx. Go to S_ACC.
- S_ACC:
  - Register lane-wise vec_r+sram_dout as signed psum_bw addition, wrapping modulo 2^psum_bw.
  - Go to S_WR.
- S_WR:
  - sram_en=1, sram_wr=1, sram_addr=base+idx.
  - sram_din = (relu_en ? max(0,lane) : lane) for each lane.
  - If idx==num_vec-1, go to S_DONE. Otherwise increment idx and go to S_POP.
- S_DONE: done=1 for this single cycle, then go to S_IDLE.
- SRAM controls are decoded from the state register. sram_din and sram_addr are 0 when sram_en=0.
- Throughput with continuous ofifo_valid: 2 cycles per vector without acc_en, 4 cycles per vector with acc_en.
- Address arithmetic: base+idx wraps modulo 2^addr_w.
- start while busy: ignored. Latched configuration is unaffected.
- Reset mid-run: immediate return to S_IDLE with reset values.
  - No write is in flight after reset.
  - A vector already popped is lost. This is accepted.
- ofifo_valid dropping after the pop cycle does not affect the current vector.

Optional Feature:
PSUM_WB_SAT_EN
- Defined: the accumulate add saturates per lane to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. ReLU is applied after saturation.
- Undefined: two's-complement wrap. No extra logic.

Decomposition:
- Package psum_wb_pkg holds:
  - state encodings S_IDLE, S_POP, S_RD, S_ACC, S_WR, S_DONE;
  - lane-slice helper constants;
  - saturation limit constants.
- Sub-module psum_lane_alu: one lane, taking a, b, add_en, relu_en and producing the result, with sat under the macro. Instantiate col times via generate.

Test Plan:
- Reset: drive reset=0 mid-cycle. All outputs are 0 asynchronously, and busy=0 after release.
- Plain writeback: num_vec=3, base=0x010, acc_en=0, ofifo always valid with all lanes = 1, 2, 3 in turn.
  - Writes hit 0x010, 0x011, 0x012 on cycles 2, 4 and 6 after start.
  - done pulses on cycle 7. ofifo_rd pulses exactly 3 times.
- Accumulate + ReLU: SRAM rows hold lanes 100 and -50, OFIFO lanes are -30, acc_en=1, relu_en=1.
  - Written values are 70 and 0. Each vector takes 4 cycles (read precedes write by 2 cycles).
- OFIFO stall: ofifo_valid=0 for 5 cycles after the first vector. The block holds in S_POP with sram_en=0 and ofifo_rd=0, then resumes correctly.
- Wrap/overflow: base=0x7FF, num_vec=2 gives addresses 0x7FF then 0x000.
  - Lane 0x7FFF+1 writes 0x8000 without PSUM_WB_SAT_EN and 0x7FFF with it.
- Edge: num_vec=0 gives done one cycle after start with no ofifo_rd and no sram_en.
  - A start pulse while busy is ignored.
  - reset asserted during S_ACC suppresses the pending write.

Source files
------------

// File: rtl/psum_wb_pkg.sv
// Shared types and helpers for the PSUM writeback controller.
// PSUM_WB_SAT_EN selects saturating accumulation in psum_lane_alu.
package psum_wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_RD   = 3'd2,
    S_ACC  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Lane i of a packed vector lives at [lane_lo(i, w) +: w].
  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// One lane of the writeback datapath: optional accumulate, then optional ReLU.
// With PSUM_WB_SAT_EN defined the add saturates instead of wrapping.
module psum_lane_alu
  import psum_wb_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                add_en,
  input  logic                relu_en,
  output logic signed [W-1:0] result
);

  logic signed [W-1:0] sum;
  logic signed [W-1:0] pre;

`ifdef PSUM_WB_SAT_EN
  localparam logic signed [W-1:0] SAT_HI = W'(sat_hi(W));
  localparam logic signed [W-1:0] SAT_LO = W'(sat_lo(W));
  logic signed [W:0] sum_ext;

  // Overflow shows up as a disagreement between the two top bits.
  always_comb begin
    sum_ext = {a[W-1], a} + {b[W-1], b};
    if (sum_ext[W] != sum_ext[W-1])
      sum = sum_ext[W] ? SAT_LO : SAT_HI;
    else
      sum = sum_ext[W-1:0];
  end
`else
  assign sum = a + b;
`endif

  always_comb begin
    pre    = add_en ? sum : a;
    result = (relu_en && pre[W-1]) ? '0 : pre;
  end

endmodule

// File: rtl/psum_wb_ctrl.sv
// Drains OFIFO vectors into PSUM SRAM rows, with optional read-modify-write
// accumulation and ReLU. Saturating accumulate when PSUM_WB_SAT_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start, config latched on start
// S_POP  | waiting for / popping the OFIFO head into vec_r
// S_RD   | reading the stored partial sum for row base+idx
// S_ACC  | registering vec_r + sram_dout back into vec_r
// S_WR   | writing (optionally ReLU'd) vec_r to row base+idx
// S_DONE | one-cycle completion pulse
module psum_wb_ctrl
  import psum_wb_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [4:0]               num_vec,
  input  logic [addr_w-1:0]        base_addr,
  input  logic                     acc_en,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     sram_en,
  output logic                     sram_wr,
  output logic [addr_w-1:0]        sram_addr,
  output logic [col*psum_bw-1:0]   sram_din,
  input  logic [col*psum_bw-1:0]   sram_dout,
  output logic                     busy,
  output logic                     done
);

  localparam int VEC_W = col * psum_bw;

  state_t              state;
  logic [4:0]          num_r;
  logic [4:0]          idx;
  logic [addr_w-1:0]   base_r;
  logic                acc_r;
  logic                relu_r;
  logic [VEC_W-1:0]    vec_r;
  logic [VEC_W-1:0]    alu_out;
  logic                alu_add;
  logic                alu_relu;
  logic [addr_w-1:0]   row_addr;

  // The lane ALUs serve both the ACC update (add, no ReLU) and the WR data path
  // (pass-through, ReLU if enabled), so ReLU always sees the post-add value.
  assign alu_add  = (state == S_ACC);
  assign alu_relu = relu_r && (state == S_WR);

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane_alu #(.W(psum_bw)) u_alu (
      .a       (vec_r[lane_lo(i, psum_bw) +: psum_bw]),
      .b       (sram_dout[lane_lo(i, psum_bw) +: psum_bw]),
      .add_en  (alu_add),
      .relu_en (alu_relu),
      .result  (alu_out[lane_lo(i, psum_bw) +: psum_bw])
    );
  end

  assign row_addr  = base_r + addr_w'(idx);
  assign ofifo_rd  = (state == S_POP) && ofifo_valid;
  assign sram_en   = (state == S_RD) || (state == S_WR);
  assign sram_wr   = (state == S_WR);
  assign sram_addr = sram_en ? row_addr : '0;
  assign sram_din  = sram_wr ? alu_out : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      num_r  <= '0;
      idx    <= '0;
      base_r <= '0;
      acc_r  <= 1'b0;
      relu_r <= 1'b0;
      vec_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_r  <= num_vec;
            base_r <= base_addr;
            acc_r  <= acc_en;
            relu_r <= relu_en;
            idx    <= '0;
            state  <= (num_vec == 5'd0) ? S_DONE : S_POP;
          end
        end
        S_POP: begin
          if (ofifo_valid) begin
            vec_r <= ofifo_out;
            state <= acc_r ? S_RD : S_WR;
          end
        end
        S_RD:  state <= S_ACC;
        S_ACC: begin
          vec_r <= alu_out;
          state <= S_WR;
        end
        S_WR: begin
          if (idx == num_r - 5'd1) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 5'd1;
            state <= S_POP;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_wb_ctrl.sv
// Directed self-checking bench for psum_wb_ctrl with an OFIFO model and a
// one-cycle-latency PSUM SRAM model.
module tb_psum_wb_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   num_vec = '0;
  logic [10:0]  base_addr = '0;
  logic         acc_en = 1'b0;
  logic         relu_en = 1'b0;
  logic         ofifo_valid;
  logic [127:0] ofifo_out;
  logic         ofifo_rd;
  logic         sram_en;
  logic         sram_wr;
  logic [10:0]  sram_addr;
  logic [127:0] sram_din;
  logic [127:0] sram_dout = '0;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;

  logic [127:0] mem [0:2047];
  logic         pre_we = 1'b0;
  logic [10:0]  pre_addr = '0;
  logic [127:0] pre_data = '0;

  int           pops = 0;
  int           pop_base = 0;
  int           fifo_len = 0;
  logic [127:0] fifo_data [0:7];

  psum_wb_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
    .base_addr   (base_addr),
    .acc_en      (acc_en),
    .relu_en     (relu_en),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .sram_en     (sram_en),
    .sram_wr     (sram_wr),
    .sram_addr   (sram_addr),
    .sram_din    (sram_din),
    .sram_dout   (sram_dout),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign ofifo_valid = ((pops - pop_base) < fifo_len);
  assign ofifo_out   = fifo_data[3'(pops - pop_base)];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_en && sram_wr) mem[sram_addr] <= sram_din;
    if (sram_en && !sram_wr) sram_dout <= mem[sram_addr];
    if (ofifo_rd) pops <= pops + 1;
  end

  function automatic logic [127:0] splat(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] alt(input logic [15:0] e, input logic [15:0] o);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = (i % 2 == 0) ? e : o;
    return r;
  endfunction

  task automatic start_run(input logic [4:0] n, input logic [10:0] b, input logic a, input logic r);
    @(posedge clk); #1;
    num_vec = n; base_addr = b; acc_en = a; relu_en = r; start = 1'b1;
    pop_base = pops;
    @(posedge clk); #1;
    start = 1'b0; num_vec = '0; base_addr = '0; acc_en = 1'b0; relu_en = 1'b0;
  endtask

  task automatic preload(input logic [10:0] a, input logic [127:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({ofifo_rd, sram_en, sram_wr, sram_addr, sram_din, busy, done} !== '0) begin
      bad++; $display("FAIL reset_outputs got en=%b rd=%b busy=%b done=%b addr=%h", sram_en, ofifo_rd, busy, done, sram_addr);
    end
    #9 reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end

    for (int i = 0; i < 8; i++) fifo_data[i] = splat(16'h0009);
    fifo_len = 8;
    start_run(5'd3, 11'h010, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sram_en !== 1'b1) begin bad++; $display("FAIL reset_prewrite en got=%b want=1", sram_en); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({ofifo_rd, sram_en, sram_wr, sram_addr, sram_din, busy, done} !== '0) begin
      bad++; $display("FAIL reset_async got en=%b wr=%b busy=%b addr=%h", sram_en, sram_wr, busy, sram_addr);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || sram_en !== 1'b0) begin bad++; $display("FAIL reset_release busy=%b en=%b want 0 0", busy, sram_en); end
    fifo_len = 0;
  endtask

  task automatic test_plain;
    logic exp_wr;
    logic [10:0] exp_a;
    fifo_data[0] = splat(16'd1);
    fifo_data[1] = splat(16'd2);
    fifo_data[2] = splat(16'd3);
    for (int i = 3; i < 8; i++) fifo_data[i] = '0;
    fifo_len = 8;
    start_run(5'd3, 11'h010, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_wr = (k == 2 || k == 4 || k == 6);
      exp_a  = 11'h010 + 11'(k / 2) - 11'd1;
      total++;
      if (sram_en !== exp_wr || sram_wr !== exp_wr) begin
        bad++; $display("FAIL plain_en k=%0d got en=%b wr=%b want %b", k, sram_en, sram_wr, exp_wr);
      end
      if (exp_wr) begin
        total++;
        if (sram_addr !== exp_a) begin bad++; $display("FAIL plain_addr k=%0d got=%h want=%h", k, sram_addr, exp_a); end
        total++;
        if (sram_din !== splat(16'(k / 2))) begin bad++; $display("FAIL plain_din k=%0d got=%h want=%h", k, sram_din, splat(16'(k / 2))); end
      end else begin
        total++;
        if (sram_addr !== '0 || sram_din !== '0) begin bad++; $display("FAIL plain_idle_bus k=%0d addr=%h din=%h want 0", k, sram_addr, sram_din); end
      end
      total++;
      if (ofifo_rd !== (k == 1 || k == 3 || k == 5)) begin bad++; $display("FAIL plain_rd k=%0d got=%b", k, ofifo_rd); end
      total++;
      if (done !== (k == 7)) begin bad++; $display("FAIL plain_done k=%0d got=%b", k, done); end
      total++;
      if (busy !== (k <= 7)) begin bad++; $display("FAIL plain_busy k=%0d got=%b", k, busy); end
    end
    total++;
    if (pops - pop_base !== 3) begin bad++; $display("FAIL plain_pops got=%0d want=3", pops - pop_base); end
    fifo_len = 0;
  endtask

  task automatic test_acc_relu;
    preload(11'h100, alt(16'd100, 16'hFFCE));
    preload(11'h101, alt(16'd100, 16'hFFCE));
    fifo_data[0] = splat(16'hFFE2);
    fifo_data[1] = splat(16'hFFE2);
    fifo_len = 2;
    start_run(5'd2, 11'h100, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      total++;
      if (sram_en !== (k == 2 || k == 4 || k == 6 || k == 8) || sram_wr !== (k == 4 || k == 8)) begin
        bad++; $display("FAIL acc_ctl k=%0d got en=%b wr=%b", k, sram_en, sram_wr);
      end
      if (k == 2 || k == 4 || k == 6 || k == 8) begin
        total++;
        if (sram_addr !== 11'h100 + 11'((k - 1) / 4)) begin bad++; $display("FAIL acc_addr k=%0d got=%h", k, sram_addr); end
      end
      if (k == 4 || k == 8) begin
        total++;
        if (sram_din !== alt(16'd70, 16'd0)) begin bad++; $display("FAIL acc_din k=%0d got=%h want=%h", k, sram_din, alt(16'd70, 16'd0)); end
      end
      total++;
      if (ofifo_rd !== (k == 1 || k == 5)) begin bad++; $display("FAIL acc_rd k=%0d got=%b", k, ofifo_rd); end
      total++;
      if (done !== (k == 9)) begin bad++; $display("FAIL acc_done k=%0d got=%b", k, done); end
    end
    fifo_len = 0;
  endtask

  task automatic test_stall;
    fifo_data[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    fifo_data[1] = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
    fifo_len = 1;
    start_run(5'd2, 11'h020, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      total++;
      if (ofifo_rd !== (k == 1 || k == 7)) begin bad++; $display("FAIL stall_rd k=%0d got=%b", k, ofifo_rd); end
      total++;
      if (sram_en !== (k == 2 || k == 8) || sram_wr !== (k == 2 || k == 8)) begin
        bad++; $display("FAIL stall_en k=%0d got en=%b wr=%b", k, sram_en, sram_wr);
      end
      if (k == 2 || k == 8) begin
        total++;
        if (sram_addr !== ((k == 2) ? 11'h020 : 11'h021)) begin bad++; $display("FAIL stall_addr k=%0d got=%h", k, sram_addr); end
        total++;
        if (sram_din !== fifo_data[(k == 2) ? 0 : 1]) begin bad++; $display("FAIL stall_din k=%0d got=%h want=%h", k, sram_din, fifo_data[(k == 2) ? 0 : 1]); end
      end
      total++;
      if (busy !== (k <= 9) || done !== (k == 9)) begin bad++; $display("FAIL stall_status k=%0d busy=%b done=%b", k, busy, done); end
      if (k == 6) begin
        @(posedge clk); #1;
        fifo_len = 2;
      end
    end
    fifo_len = 0;
  endtask

  task automatic test_wrap;
    logic [127:0] exp_d;
`ifdef PSUM_WB_SAT_EN
    exp_d = alt(16'h7FFF, 16'h8000);
`else
    exp_d = alt(16'h8000, 16'h7FFF);
`endif
    preload(11'h7FF, alt(16'h0001, 16'hFFFF));
    preload(11'h000, alt(16'h0001, 16'hFFFF));
    fifo_data[0] = alt(16'h7FFF, 16'h8000);
    fifo_data[1] = alt(16'h7FFF, 16'h8000);
    fifo_len = 2;
    start_run(5'd2, 11'h7FF, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 2 || k == 4 || k == 6 || k == 8) begin
        total++;
        if (sram_en !== 1'b1 || sram_addr !== ((k <= 4) ? 11'h7FF : 11'h000)) begin
          bad++; $display("FAIL wrap_addr k=%0d en=%b got=%h", k, sram_en, sram_addr);
        end
      end
      if (k == 4 || k == 8) begin
        total++;
        if (sram_din !== exp_d) begin bad++; $display("FAIL wrap_din k=%0d got=%h want=%h", k, sram_din, exp_d); end
      end
      if (k == 9) begin
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b want=1", done); end
      end
    end
    fifo_len = 0;
  endtask

  task automatic test_edge;
    // zero-length run
    fifo_data[0] = splat(16'h0042);
    fifo_len = 4;
    start_run(5'd0, 11'h055, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || ofifo_rd !== 1'b0 || sram_en !== 1'b0) begin
      bad++; $display("FAIL zero_c1 done=%b busy=%b rd=%b en=%b want 1 1 0 0", done, busy, ofifo_rd, sram_en);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || ofifo_rd !== 1'b0 || sram_en !== 1'b0) begin
      bad++; $display("FAIL zero_c2 done=%b busy=%b rd=%b en=%b want 0 0 0 0", done, busy, ofifo_rd, sram_en);
    end
    total++;
    if (pops - pop_base !== 0) begin bad++; $display("FAIL zero_pops got=%0d want=0", pops - pop_base); end

    // start while busy must not disturb the latched configuration
    fifo_len = 0;
    start_run(5'd1, 11'h030, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || ofifo_rd !== 1'b0) begin bad++; $display("FAIL busy_hold busy=%b rd=%b want 1 0", busy, ofifo_rd); end
    @(posedge clk); #1;
    start = 1'b1; num_vec = 5'd5; base_addr = 11'h200; acc_en = 1'b1; relu_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; num_vec = '0; base_addr = '0; acc_en = 1'b0; relu_en = 1'b0;
    fifo_data[0] = splat(16'hFFF0);
    fifo_len = 1;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) begin
        total++;
        if (ofifo_rd !== 1'b1 || sram_en !== 1'b0) begin bad++; $display("FAIL restart_pop rd=%b en=%b want 1 0", ofifo_rd, sram_en); end
      end else if (k == 4) begin
        total++;
        if (sram_en !== 1'b1 || sram_wr !== 1'b1 || sram_addr !== 11'h030) begin
          bad++; $display("FAIL restart_wr en=%b wr=%b got addr=%h want 1 1 030", sram_en, sram_wr, sram_addr);
        end
        total++;
        if (sram_din !== splat(16'hFFF0)) begin bad++; $display("FAIL restart_din got=%h want=%h", sram_din, splat(16'hFFF0)); end
      end else if (k == 5) begin
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b want=1", done); end
      end else begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL restart_idle busy=%b want=0", busy); end
      end
    end

    // reset during S_ACC drops the pending write
    preload(11'h040, splat(16'd5));
    fifo_data[0] = splat(16'd7);
    fifo_len = 1;
    start_run(5'd1, 11'h040, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sram_en !== 1'b1 || sram_wr !== 1'b0) begin bad++; $display("FAIL accrst_rd en=%b wr=%b want 1 0", sram_en, sram_wr); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || sram_en !== 1'b0) begin bad++; $display("FAIL accrst_async busy=%b en=%b want 0 0", busy, sram_en); end
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (sram_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL accrst_quiet k=%0d en=%b busy=%b want 0 0", k, sram_en, busy); end
    end
    total++;
    if (mem[11'h040] !== splat(16'd5)) begin bad++; $display("FAIL accrst_row got=%h want=%h", mem[11'h040], splat(16'd5)); end
    fifo_len = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) fifo_data[i] = '0;
    test_reset();
    test_plain();
    test_acc_relu();
    test_stall();
    test_wrap();
    test_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
